mem_port_arbiter: RTL and testbench

- Shares the core's single memory bus port between the instruction-fetch requester and the load/store (data) requester.
- Sits between the IF/MEM stages and the external memory.
- Produces the `inst_stall`/`data_stall` signals consumed by hazard_unit.
- Serialises requests through a small FSM:
  - data wins over fetch by default;
  - fetch is granted after a data transfer if it was waiting, so it cannot starve.

---
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle around mem_port_arbiter: master is the arbiter's view, slave the environment's.
// err_out is present only when MEM_ARB_TIMEOUT_EN is defined.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                inst_stb_in;
  logic [ADDR_W-1:0]   inst_addr_in;
  logic                inst_ack_out;
  logic [DATA_W-1:0]   inst_data_out;
  logic                inst_stall_out;
  logic                data_stb_in;
  logic                data_we_in;
  logic [DATA_W/8-1:0] data_be_in;
  logic [ADDR_W-1:0]   data_addr_in;
  logic [DATA_W-1:0]   data_wdata_in;
  logic                data_ack_out;
  logic [DATA_W-1:0]   data_rdata_out;
  logic                data_stall_out;
  logic                mem_stb_out;
  logic                mem_we_out;
  logic [DATA_W/8-1:0] mem_be_out;
  logic [ADDR_W-1:0]   mem_addr_out;
  logic [DATA_W-1:0]   mem_wdata_out;
  logic                mem_ack_in;
  logic [DATA_W-1:0]   mem_rdata_in;
  logic                grant_data_out;
`ifdef MEM_ARB_TIMEOUT_EN
  logic                err_out;
`endif

  modport master (
    input  inst_stb_in, inst_addr_in, data_stb_in, data_we_in, data_be_in, data_addr_in,
           data_wdata_in, mem_ack_in, mem_rdata_in,
    output inst_ack_out, inst_data_out, inst_stall_out, data_ack_out, data_rdata_out,
           data_stall_out, mem_stb_out, mem_we_out, mem_be_out, mem_addr_out, mem_wdata_out,
           grant_data_out
`ifdef MEM_ARB_TIMEOUT_EN
    , output err_out
`endif
  );

  modport slave (
    output inst_stb_in, inst_addr_in, data_stb_in, data_we_in, data_be_in, data_addr_in,
           data_wdata_in, mem_ack_in, mem_rdata_in,
    input  inst_ack_out, inst_data_out, inst_stall_out, data_ack_out, data_rdata_out,
           data_stall_out, mem_stb_out, mem_we_out, mem_be_out, mem_addr_out, mem_wdata_out,
           grant_data_out
`ifdef MEM_ARB_TIMEOUT_EN
    , input err_out
`endif
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch and load/store with alternating priority.
// Optional WAIT-state abort with err_out is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 255
`endif
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [2:0] {StIdle, StIWait, StDWait, StIResp, StDResp} state_e;

  state_e state_q;
  logic   last_was_data_q;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);
  logic [CntW-1:0] wait_cnt_q;
`endif

  assign bus.inst_stall_out = bus.inst_stb_in & ~bus.inst_ack_out;
  assign bus.data_stall_out = bus.data_stb_in & ~bus.data_ack_out;
  assign bus.grant_data_out = last_was_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= StIdle;
      last_was_data_q    <= 1'b0;
      bus.inst_ack_out   <= 1'b0;
      bus.inst_data_out  <= '0;
      bus.data_ack_out   <= 1'b0;
      bus.data_rdata_out <= '0;
      bus.mem_stb_out    <= 1'b0;
      bus.mem_we_out     <= 1'b0;
      bus.mem_be_out     <= '0;
      bus.mem_addr_out   <= '0;
      bus.mem_wdata_out  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      bus.err_out        <= 1'b0;
      wait_cnt_q         <= '0;
`endif
    end else begin
      bus.inst_ack_out <= 1'b0;
      bus.data_ack_out <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      bus.err_out      <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          // Data wins unless fetch is also waiting and data had the previous transfer.
          if (bus.data_stb_in && !(bus.inst_stb_in && last_was_data_q)) begin
            bus.mem_stb_out   <= 1'b1;
            bus.mem_we_out    <= bus.data_we_in;
            bus.mem_be_out    <= bus.data_be_in;
            bus.mem_addr_out  <= bus.data_addr_in;
            bus.mem_wdata_out <= bus.data_wdata_in;
            last_was_data_q   <= 1'b1;
            state_q           <= StDWait;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt_q        <= '0;
`endif
          end else if (bus.inst_stb_in) begin
            bus.mem_stb_out   <= 1'b1;
            bus.mem_we_out    <= 1'b0;
            bus.mem_be_out    <= '1;
            bus.mem_addr_out  <= bus.inst_addr_in;
            bus.mem_wdata_out <= '0;
            last_was_data_q   <= 1'b0;
            state_q           <= StIWait;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt_q        <= '0;
`endif
          end
        end
        StIWait, StDWait: begin
          if (bus.mem_ack_in) begin
            bus.mem_stb_out <= 1'b0;
            if (state_q == StIWait) begin
              bus.inst_data_out <= bus.mem_rdata_in;
              bus.inst_ack_out  <= 1'b1;
              state_q           <= StIResp;
            end else begin
              bus.data_rdata_out <= bus.mem_rdata_in;
              bus.data_ack_out   <= 1'b1;
              state_q            <= StDResp;
            end
`ifdef MEM_ARB_TIMEOUT_EN
          end else if (wait_cnt_q == CntW'(TIMEOUT - 1)) begin
            // Abort: complete the request with zero data and flag the error for one cycle.
            bus.mem_stb_out <= 1'b0;
            bus.err_out     <= 1'b1;
            if (state_q == StIWait) begin
              bus.inst_data_out <= '0;
              bus.inst_ack_out  <= 1'b1;
              state_q           <= StIResp;
            end else begin
              bus.data_rdata_out <= '0;
              bus.data_ack_out   <= 1'b1;
              state_q            <= StDResp;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
`endif
          end
        end
        StIResp, StDResp: state_q <= StIdle;
        default:          state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory slave and an expected-transfer queue.
// Timeout scenario is exercised only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rdata;
    logic [31:0] rdata;
    logic        err;
  } xfer_t;

  logic clk;
  logic reset;
  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  xfer_t       exp_q[$];
  xfer_t       mon_e;
  logic        seen_stb   = 1'b0;
  logic        prev_ack   = 1'b0;
  logic        slave_en   = 1'b1;
  int          slave_delay = 2;
  int          slv_cnt    = 0;
  logic        slv_ack    = 1'b0;
  logic [31:0] slv_rdata  = '0;
  logic        force_ack  = 1'b0;

  assign bus.mem_ack_in   = slv_ack | force_ack;
  assign bus.mem_rdata_in = slv_rdata;

  function automatic logic [31:0] slave_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic d, input logic we, input logic [3:0] be,
                      input logic [31:0] a, input logic [31:0] wd, input logic err);
    xfer_t e;
    e.is_data   = d;
    e.we        = we;
    e.be        = be;
    e.addr      = a;
    e.wdata     = wd;
    e.chk_rdata = !we;
    e.rdata     = err ? 32'h0 : slave_model(a);
    e.err       = err;
    exp_q.push_back(e);
  endtask

  // Waits for the requested side's ack, checking its stall output meanwhile.
  task automatic wait_ack(input logic want_data, input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (want_data ? bus.data_ack_out : bus.inst_ack_out) got = 1'b1;
      else chk(want_data ? "data_stall_wait" : "inst_stall_wait",
               want_data ? bus.data_stall_out : bus.inst_stall_out, 1);
    end
    chk(want_data ? "data_ack_seen" : "inst_ack_seen", got, 1);
    chk(want_data ? "data_stall_ack" : "inst_stall_ack",
        want_data ? bus.data_stall_out : bus.inst_stall_out, 0);
    if (want_data) bus.data_stb_in = 1'b0;
    else bus.inst_stb_in = 1'b0;
    tick();
    chk(want_data ? "data_ack_pulse" : "inst_ack_pulse",
        want_data ? bus.data_ack_out : bus.inst_ack_out, 0);
  endtask

  task automatic data_req(input logic we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd);
    push(1'b1, we, be, a, wd, 1'b0);
    bus.data_we_in    = we;
    bus.data_be_in    = be;
    bus.data_addr_in  = a;
    bus.data_wdata_in = wd;
    bus.data_stb_in   = 1'b1;
    #1;
    chk("data_stall_req", bus.data_stall_out, 1);
  endtask

  task automatic inst_req(input logic [31:0] a);
    push(1'b0, 1'b0, 4'hF, a, 32'h0, 1'b0);
    bus.inst_addr_in = a;
    bus.inst_stb_in  = 1'b1;
    #1;
    chk("inst_stall_req", bus.inst_stall_out, 1);
  endtask

  // Behavioural slave: acks slave_delay cycles after it first sees mem_stb_out.
  always @(posedge clk) begin
    #1;
    slv_ack = 1'b0;
    if (reset || !slave_en || !bus.mem_stb_out) slv_cnt = 0;
    else if (slv_cnt == slave_delay) begin
      slv_ack   = 1'b1;
      slv_rdata = slave_model(bus.mem_addr_out);
      slv_cnt   = 0;
    end else slv_cnt++;
  end

  // Scoreboard monitor: bus fields at grant, owner/data/latency at ack.
  always @(negedge clk) begin
    if (reset) seen_stb = 1'b0;
    else begin
      if (bus.mem_stb_out && !seen_stb) begin
        seen_stb = 1'b1;
        if (exp_q.size() == 0) chk("unexpected_stb", bus.mem_stb_out, 0);
        else begin
          mon_e = exp_q[0];
          chk("grant_data", bus.grant_data_out, mon_e.is_data);
          chk("mem_we", bus.mem_we_out, mon_e.we);
          chk("mem_be", bus.mem_be_out, mon_e.be);
          chk("mem_addr", bus.mem_addr_out, mon_e.addr);
          if (mon_e.we) chk("mem_wdata", bus.mem_wdata_out, mon_e.wdata);
        end
      end
      if (bus.inst_ack_out || bus.data_ack_out) begin
        if (exp_q.size() == 0) chk("unexpected_ack", bus.inst_ack_out | bus.data_ack_out, 0);
        else begin
          mon_e = exp_q.pop_front();
          seen_stb = 1'b0;
          chk("ack_owner_data", bus.data_ack_out, mon_e.is_data);
          chk("ack_owner_inst", bus.inst_ack_out, !mon_e.is_data);
          chk("mem_stb_in_resp", bus.mem_stb_out, 0);
          if (!mon_e.err) chk("ack_latency", prev_ack, 1);
          if (mon_e.chk_rdata)
            chk(mon_e.is_data ? "data_rdata" : "inst_data",
                mon_e.is_data ? bus.data_rdata_out : bus.inst_data_out, mon_e.rdata);
`ifdef MEM_ARB_TIMEOUT_EN
          chk("err_out", bus.err_out, mon_e.err);
`endif
        end
      end
    end
    prev_ack = bus.mem_ack_in;
  end

  initial begin
    reset             = 1'b1;
    bus.inst_stb_in   = 1'b0;
    bus.inst_addr_in  = '0;
    bus.data_stb_in   = 1'b0;
    bus.data_we_in    = 1'b0;
    bus.data_be_in    = '0;
    bus.data_addr_in  = '0;
    bus.data_wdata_in = '0;
    repeat (3) tick();
    chk("rst_mem_stb", bus.mem_stb_out, 0);
    chk("rst_mem_we", bus.mem_we_out, 0);
    chk("rst_mem_be", bus.mem_be_out, 0);
    chk("rst_mem_addr", bus.mem_addr_out, 0);
    chk("rst_mem_wdata", bus.mem_wdata_out, 0);
    chk("rst_inst_ack", bus.inst_ack_out, 0);
    chk("rst_data_ack", bus.data_ack_out, 0);
    chk("rst_inst_data", bus.inst_data_out, 0);
    chk("rst_data_rdata", bus.data_rdata_out, 0);
    chk("rst_grant_data", bus.grant_data_out, 0);
    chk("rst_inst_stall", bus.inst_stall_out, 0);
    chk("rst_data_stall", bus.data_stall_out, 0);
`ifdef MEM_ARB_TIMEOUT_EN
    chk("rst_err", bus.err_out, 0);
`endif
    reset = 1'b0;
    tick();

    // Single fetch, store, load.
    inst_req(32'h100);
    wait_ack(1'b0, 20);
    data_req(1'b1, 4'b0011, 32'h2000, 32'h12345678);
    wait_ack(1'b1, 20);
    data_req(1'b0, 4'hF, 32'h3004, 32'hFFFF0000);
    wait_ack(1'b1, 20);

    // Address change while pending must not disturb the captured request.
    slave_delay = 4;
    inst_req(32'h700);
    tick();
    tick();
    bus.inst_addr_in = 32'h7FC;
    tick();
    chk("addr_held", bus.mem_addr_out, 32'h700);
    wait_ack(1'b0, 20);
    slave_delay = 2;

    // Both requesting from reset: D, I, D, I.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    push(1'b1, 1'b0, 4'hF, 32'h4000, 32'h0, 1'b0);
    push(1'b0, 1'b0, 4'hF, 32'h500, 32'h0, 1'b0);
    push(1'b1, 1'b0, 4'hF, 32'h4010, 32'h0, 1'b0);
    push(1'b0, 1'b0, 4'hF, 32'h510, 32'h0, 1'b0);
    bus.data_we_in   = 1'b0;
    bus.data_be_in   = 4'hF;
    bus.data_addr_in = 32'h4000;
    bus.inst_addr_in = 32'h500;
    bus.data_stb_in  = 1'b1;
    bus.inst_stb_in  = 1'b1;
    for (int r = 0; r < 4; r++) begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        tick();
        if (bus.data_ack_out || bus.inst_ack_out) got = 1'b1;
      end
      chk("alt_ack_seen", got, 1);
      if (bus.data_ack_out) begin
        bus.data_stb_in = 1'b0;
        if (r < 2) begin
          tick();
          bus.data_addr_in = 32'h4010;
          bus.data_stb_in  = 1'b1;
        end
      end else if (bus.inst_ack_out) begin
        bus.inst_stb_in = 1'b0;
        if (r < 2) begin
          tick();
          bus.inst_addr_in = 32'h510;
          bus.inst_stb_in  = 1'b1;
        end
      end
    end
    tick();
    chk("alt_queue_empty", exp_q.size(), 0);

    // mem_ack_in while idle is ignored; read outputs hold.
    slave_en  = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_ack_inst", bus.inst_ack_out, 0);
      chk("idle_ack_data", bus.data_ack_out, 0);
      chk("idle_mem_stb", bus.mem_stb_out, 0);
      tick();
    end
    chk("hold_inst_data", bus.inst_data_out, slave_model(32'h510));
    chk("hold_data_rdata", bus.data_rdata_out, slave_model(32'h4010));

    // Reset during D_WAIT drops the transfer; a late ack is ignored.
    data_req(1'b0, 4'hF, 32'h3000, 32'h0);
    tick();
    tick();
    chk("dwait_stb", bus.mem_stb_out, 1);
    reset           = 1'b1;
    bus.data_stb_in = 1'b0;
    exp_q.delete();
    tick();
    chk("rstmid_stb", bus.mem_stb_out, 0);
    chk("rstmid_ack", bus.data_ack_out, 0);
    chk("rstmid_grant", bus.grant_data_out, 0);
    reset     = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("late_ack_data", bus.data_ack_out, 0);
      chk("late_ack_stb", bus.mem_stb_out, 0);
      tick();
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Silent slave: abort after 255 WAIT cycles.
    begin
      int   stb_cycles;
      logic got;
      stb_cycles = 0;
      got        = 1'b0;
      push(1'b1, 1'b0, 4'hF, 32'h6000, 32'h0, 1'b1);
      bus.data_addr_in = 32'h6000;
      bus.data_stb_in  = 1'b1;
      for (int i = 0; i < 400 && !got; i++) begin
        tick();
        if (bus.mem_stb_out) stb_cycles++;
        if (bus.data_ack_out) got = 1'b1;
      end
      chk("to_ack_seen", got, 1);
      chk("to_stb_cycles", stb_cycles, 255);
      chk("to_rdata", bus.data_rdata_out, 0);
      bus.data_stb_in = 1'b0;
      tick();
      chk("to_err_pulse", bus.err_out, 0);
      chk("to_ack_pulse", bus.data_ack_out, 0);
    end
`endif
    slave_en = 1'b1;
    tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
